bist_response_analyzer: RTL

Response-analysis half of the memory BIST: the march controller and pattern generator drive the RAM; this block consumes every read-compare event, compacts read data into a 16-bit MISR signature and logs failures. It sits beside the controller in the `bist` top and reports to the `fail` and diagnostic outputs.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_misr.sv | 37 +++
 rtl/bist_response_analyzer.sv | 84 ++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared memory-BIST definitions: RAM geometry, MISR constants and analyzer states.
package bist_pkg;

    localparam int unsigned AW   = 6;
    localparam int unsigned DW   = 8;
    localparam int unsigned SIGW = 16;

    localparam logic [SIGW-1:0] MISR_POLY = 16'h1021;
    localparam logic [SIGW-1:0] MISR_SEED = 16'h0000;

    typedef enum logic [1:0] {
        RA_IDLE = 2'd0,
        RA_RUN  = 2'd1,
        RA_DONE = 2'd2
    } ra_state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting BIST read data into a signature.
module bist_misr
    import bist_pkg::*;
#(
    parameter int unsigned     SIGW = bist_pkg::SIGW,
    parameter int unsigned     DW   = bist_pkg::DW,
    parameter logic [SIGW-1:0] POLY = MISR_POLY,
    parameter logic [SIGW-1:0] SEED = MISR_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [DW-1:0]   din,
    output logic [SIGW-1:0] sig
);

    logic [SIGW-1:0] sig_next;

    // Shift with feedback on the MSB, then fold the read word into the low bits.
    always_comb begin
        sig_next = {sig[SIGW-2:0], 1'b0}
                 ^ (sig[SIGW-1] ? POLY : '0)
                 ^ {{(SIGW-DW){1'b0}}, din};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts read data into a MISR and logs compare failures.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned AW   = bist_pkg::AW,
    parameter int unsigned DW   = bist_pkg::DW,
    parameter int unsigned SIGW = bist_pkg::SIGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cmp_valid,
    input  logic [AW-1:0]   cmp_addr,
    input  logic [DW-1:0]   cmp_expected,
    input  logic [DW-1:0]   cmp_actual,
    input  logic            done_in,
    input  logic [SIGW-1:0] golden_sig,
    output logic            busy,
    output logic            done,
    output logic            fail,
    output logic [7:0]      fail_count,
    output logic [AW-1:0]   first_fail_addr,
    output logic [DW-1:0]   first_fail_syn,
    output logic [SIGW-1:0] signature,
    output logic            pass
);

    ra_state_t state;
    logic      accept;
    logic      mismatch;

    // start has priority: a compare arriving with start is discarded.
    assign accept   = (state == RA_RUN) && cmp_valid && !start;
    assign mismatch = cmp_actual != cmp_expected;

    bist_misr #(
        .SIGW (SIGW),
        .DW   (DW),
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .en  (accept),
        .din (cmp_actual),
        .sig (signature)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= RA_IDLE;
            fail            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_syn  <= '0;
        end else if (start) begin
            state           <= RA_RUN;
            fail            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            first_fail_syn  <= '0;
        end else if (state == RA_RUN) begin
            if (cmp_valid && mismatch) begin
                fail <= 1'b1;
                if (fail_count != '1) begin
                    fail_count <= fail_count + 8'd1;
                end
                if (!fail) begin
                    first_fail_addr <= cmp_addr;
                    first_fail_syn  <= cmp_expected ^ cmp_actual;
                end
            end
            if (done_in) begin
                state <= RA_DONE;
            end
        end
    end

    assign busy = (state == RA_RUN);
    assign done = (state == RA_DONE);
    assign pass = done && !fail && (signature == golden_sig);

endmodule
